// File: rtl/vs_sr_latch_driver.sv
// rtl/vs_sr_latch_driver.sv - valid/ready to timed active-low set_n/reset_n pulse driver for an SR latch
// Tracks the expected latch state so redundant requests can complete without a pulse.
module vs_sr_latch_driver #(
  parameter int PULSE_W        = 4,
  parameter int GAP_W          = 2,
  parameter int SKIP_REDUNDANT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_val,
  output logic req_ready,
  output logic set_n,
  output logic reset_n,
  output logic busy,
  output logic done,
  output logic q_model,
  output logic q_known
);

  if (PULSE_W < 1 || PULSE_W > 255) begin : g_pulse_w_check
    $error("vs_sr_latch_driver: PULSE_W must be 1..255");
  end
  if (GAP_W < 0 || GAP_W > 255) begin : g_gap_w_check
    $error("vs_sr_latch_driver: GAP_W must be 0..255");
  end

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] GAP_LAST   = (GAP_W > 0) ? 8'(GAP_W - 1) : 8'd0;
  localparam logic       HAS_GAP    = (GAP_W > 0);
  localparam logic       SKIP_EN    = (SKIP_REDUNDANT != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       val_q, val_d;
  logic       done_d, q_model_d, q_known_d;
  logic       set_n_d, reset_n_d, busy_d, req_ready_d;
  logic       accept, redundant;

  assign accept    = req_valid && req_ready;
  assign redundant = SKIP_EN && q_known && (req_val == q_model);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      val_q     <= 1'b0;
      set_n     <= 1'b1;
      reset_n   <= 1'b1;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      q_model   <= 1'b0;
      q_known   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      val_q     <= val_d;
      set_n     <= set_n_d;
      reset_n   <= reset_n_d;
      req_ready <= req_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      q_model   <= q_model_d;
      q_known   <= q_known_d;
    end
  end

  // The counter restarts at every state entry and counts up to the last cycle of that state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    done_d    = 1'b0;
    q_model_d = q_model;
    q_known_d = q_known;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (redundant) begin
            done_d = 1'b1;
          end else begin
            state_d = PULSE;
            cnt_d   = 8'd0;
            val_d   = req_val;
          end
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          q_model_d = val_q;
          q_known_d = 1'b1;
          cnt_d     = 8'd0;
          if (HAS_GAP) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops glitch-free.
  always_comb begin
    set_n_d     = !((state_d == PULSE) && val_d);
    reset_n_d   = !((state_d == PULSE) && !val_d);
    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_vs_sr_latch_driver.sv
// tb/tb_vs_sr_latch_driver.sv - directed self-checking bench for vs_sr_latch_driver
// Three instances: (4,2), (4,0) and (1,255) pulse/gap configurations.
module tb_vs_sr_latch_driver;

  logic clk;
  logic rst_n     [3];
  logic req_valid [3];
  logic req_val   [3];
  logic req_ready [3];
  logic set_n     [3];
  logic reset_n   [3];
  logic busy      [3];
  logic done      [3];
  logic q_model   [3];
  logic q_known   [3];
  int   acc       [3];

  int n_checks = 0;
  int n_pass   = 0;

  vs_sr_latch_driver #(.PULSE_W(4), .GAP_W(2), .SKIP_REDUNDANT(1)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_val(req_val[0]),
    .req_ready(req_ready[0]), .set_n(set_n[0]), .reset_n(reset_n[0]), .busy(busy[0]),
    .done(done[0]), .q_model(q_model[0]), .q_known(q_known[0])
  );

  vs_sr_latch_driver #(.PULSE_W(4), .GAP_W(0), .SKIP_REDUNDANT(1)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_val(req_val[1]),
    .req_ready(req_ready[1]), .set_n(set_n[1]), .reset_n(reset_n[1]), .busy(busy[1]),
    .done(done[1]), .q_model(q_model[1]), .q_known(q_known[1])
  );

  vs_sr_latch_driver #(.PULSE_W(1), .GAP_W(255), .SKIP_REDUNDANT(1)) dut_c (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_val(req_val[2]),
    .req_ready(req_ready[2]), .set_n(set_n[2]), .reset_n(reset_n[2]), .busy(busy[2]),
    .done(done[2]), .q_model(q_model[2]), .q_known(q_known[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++)
      if (rst_n[d] && req_valid[d] && req_ready[d]) acc[d] <= acc[d] + 1;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      check("never_both_low", {31'd0, set_n[d] | reset_n[d]}, 32'd1);
  end

  // Issue one request at the current negedge and watch `horizon` cycles after the accept edge.
  task automatic txn(input int d, input logic v, input int pw, input int done_at,
                     input int horizon, input bit hold, input string tag);
    int good_low, stray, done_cnt, done_k, acc0, drop_k;
    logic ready1, busy1;
    good_low = 0; stray = 0; done_cnt = 0; done_k = -1;
    ready1 = 1'b1; busy1 = 1'b0;
    drop_k = hold ? done_at : 1;
    check({tag, "_ready_before"}, {31'd0, req_ready[d]}, 32'd1);
    acc0 = acc[d];
    req_valid[d] = 1'b1;
    req_val[d]   = v;
    for (int k = 1; k <= horizon; k++) begin
      @(negedge clk);
      if ((v ? !set_n[d] : !reset_n[d]) && k <= pw) good_low++;
      if ((v ? !reset_n[d] : !set_n[d]) || (k > pw && (!set_n[d] || !reset_n[d]))) stray++;
      if (done[d]) begin done_cnt++; done_k = k; end
      if (k == 1) begin ready1 = req_ready[d]; busy1 = busy[d]; end
      if (k == drop_k) req_valid[d] = 1'b0;
    end
    check({tag, "_pulse_len"},  good_low, pw);
    check({tag, "_stray_low"},  stray, 0);
    check({tag, "_done_cycle"}, done_k, done_at);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_accepts"},    acc[d] - acc0, 1);
    check({tag, "_ready_c1"},   {31'd0, ready1}, (pw == 0) ? 32'd1 : 32'd0);
    check({tag, "_busy_c1"},    {31'd0, busy1},  (pw == 0) ? 32'd0 : 32'd1);
    check({tag, "_q_model"},    {31'd0, q_model[d]}, {31'd0, v});
    check({tag, "_q_known"},    {31'd0, q_known[d]}, 32'd1);
  endtask

  initial begin
    int dn;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_val[d] = 1'b0; acc[d] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_set_n",   {31'd0, set_n[d]},     32'd1);
      check("rst_reset_n", {31'd0, reset_n[d]},   32'd1);
      check("rst_ready",   {31'd0, req_ready[d]}, 32'd1);
      check("rst_busy",    {31'd0, busy[d]},      32'd0);
      check("rst_done",    {31'd0, done[d]},      32'd0);
      check("rst_q_model", {31'd0, q_model[d]},   32'd0);
      check("rst_q_known", {31'd0, q_known[d]},   32'd0);
      rst_n[d] = 1'b1;
    end
    @(negedge clk);

    // A: first set pulses, repeats are redundant and back-to-back, held reset request
    txn(0, 1'b1, 4, 7, 8, 1'b0, "t1_set");
    txn(0, 1'b1, 0, 1, 1, 1'b0, "t2_redund_a");
    txn(0, 1'b1, 0, 1, 3, 1'b0, "t2_redund_b");
    txn(0, 1'b0, 4, 7, 8, 1'b1, "t3_hold_rst");

    // B: no gap, alternating back-to-back requests
    txn(1, 1'b1, 4, 5, 5, 1'b0, "t4_alt0");
    txn(1, 1'b0, 4, 5, 5, 1'b0, "t4_alt1");
    txn(1, 1'b1, 4, 5, 6, 1'b0, "t4_alt2");

    // C: one-cycle pulse, maximal gap
    txn(2, 1'b1, 1, 257, 258, 1'b0, "t6_long_gap");

    // A: reset during the second pulse cycle
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    check("t5_known_after_rst", {31'd0, q_known[0]}, 32'd0);
    req_valid[0] = 1'b1; req_val[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t5_pulse_c2", {31'd0, set_n[0]}, 32'd0);
    #2 rst_n[0] = 1'b0;
    #1;
    check("t5_async_set_n",   {31'd0, set_n[0]},     32'd1);
    check("t5_async_reset_n", {31'd0, reset_n[0]},   32'd1);
    check("t5_async_known",   {31'd0, q_known[0]},   32'd0);
    check("t5_async_busy",    {31'd0, busy[0]},      32'd0);
    check("t5_async_ready",   {31'd0, req_ready[0]}, 32'd1);
    dn = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done[0]) dn++;
    end
    rst_n[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done[0]) dn++;
    end
    check("t5_no_done", dn, 0);
    txn(0, 1'b1, 4, 7, 8, 1'b0, "t5_repulse");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
